// File: rtl/miriscv_fetch.sv
// Instruction fetch stage: one outstanding memory request, two-entry {pc, instr}
// buffer towards decode, and redirect handling that drops in-flight responses.
module miriscv_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } state_t;

    state_t      state_reg, state_next;
    logic [31:0] pc_reg;
    logic [31:0] req_addr_reg;
    logic [1:0]  count_reg;
    logic        rd_ptr_reg;
    logic        wr_ptr_reg;
    logic [31:0] fifo_pc_reg    [2];
    logic [31:0] fifo_instr_reg [2];
    logic        grant;
    logic        push;
    logic        pop;

    // A request is only raised when the response is guaranteed a free slot.
    assign imem_req  = (state_reg == IDLE) && !redirect_valid && !rst && (count_reg < 2'd2);
    assign imem_addr = pc_reg;
    assign grant     = imem_req && imem_gnt;
    assign push      = (state_reg == WAIT) && imem_rvalid && !redirect_valid;
    assign if_valid  = (count_reg != 2'd0);
    assign pop       = if_valid && if_ready && !redirect_valid;
    assign if_instr  = fifo_instr_reg[rd_ptr_reg];
    assign if_pc     = fifo_pc_reg[rd_ptr_reg];

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (grant) state_next = WAIT;
            WAIT: begin
                if (imem_rvalid)         state_next = IDLE;
                else if (redirect_valid) state_next = DROP;
            end
            DROP: if (imem_rvalid) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            pc_reg       <= RESET_PC;
            req_addr_reg <= '0;
            count_reg    <= 2'd0;
            rd_ptr_reg   <= 1'b0;
            wr_ptr_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (grant) req_addr_reg <= pc_reg;
            if (redirect_valid) begin
                pc_reg     <= redirect_pc & 32'hFFFF_FFFC;
                count_reg  <= 2'd0;
                rd_ptr_reg <= 1'b0;
                wr_ptr_reg <= 1'b0;
            end else begin
                if (grant) pc_reg <= pc_reg + 32'd4;
                count_reg <= count_reg + {1'b0, push} - {1'b0, pop};
                if (push) wr_ptr_reg <= ~wr_ptr_reg;
                if (pop)  rd_ptr_reg <= ~rd_ptr_reg;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_entry
            always_ff @(posedge clk) begin
                if (rst) begin
                    fifo_pc_reg[gi]    <= '0;
                    fifo_instr_reg[gi] <= '0;
                end else if (push && (wr_ptr_reg == 1'(gi))) begin
                    fifo_pc_reg[gi]    <= req_addr_reg;
                    fifo_instr_reg[gi] <= imem_rdata;
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_miriscv_fetch.sv
// Bench for miriscv_fetch: directed scenarios plus a randomized run checked
// against a queue-based model of the fetch behaviour.
module tb_miriscv_fetch;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic        imem_req, imem_gnt = 1'b0, imem_rvalid = 1'b0;
    logic [31:0] imem_addr, imem_rdata = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        if_valid, if_ready = 1'b0;
    logic [31:0] if_instr, if_pc;

    logic        w_req, w_valid;
    logic        w_rvalid = 1'b0;
    logic [31:0] w_addr, w_instr, w_pc;
    logic [31:0] w_rdata = '0;

    miriscv_fetch #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr), .if_pc(if_pc)
    );

    miriscv_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
        .clk(clk), .rst(rst),
        .imem_req(w_req), .imem_addr(w_addr), .imem_gnt(1'b1),
        .imem_rvalid(w_rvalid), .imem_rdata(w_rdata),
        .redirect_valid(1'b0), .redirect_pc(32'h0000_0000),
        .if_valid(w_valid), .if_ready(1'b1), .if_instr(w_instr), .if_pc(w_pc)
    );

    // Always-granting memory with one-cycle latency for the wrap instance.
    always @(posedge clk) begin
        w_rvalid <= w_req;
        w_rdata  <= w_addr ^ 32'hA5A5_0000;
    end

    int errors = 0;
    int checks = 0;

    // Memory model for the main instance.
    bit          mem_busy = 0;
    logic [31:0] mem_addr = '0;
    int          mem_delay = 0;
    int          gnt_mode = 1;      // 0: never, 1: whenever free, 2: random
    int          lat_min = 0, lat_max = 0;
    bit          spurious_en = 0;

    // Reference model: expected buffer contents, fetch pc and in-flight request.
    logic [31:0] q_pc[$];
    logic [31:0] q_in[$];
    logic [31:0] m_pc = 32'h0;
    bit          m_out = 0, m_drop = 0;
    logic [31:0] m_addr = 32'h0;

    task automatic prep();
        imem_rvalid = 1'b0;
        imem_rdata  = $urandom;
        if (mem_busy && mem_delay == 0) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_addr ^ 32'hA5A5_0000;
        end else if (!mem_busy && spurious_en && $urandom_range(0, 7) == 0) begin
            imem_rvalid = 1'b1;
        end
        case (gnt_mode)
            0:       imem_gnt = 1'b0;
            1:       imem_gnt = !mem_busy;
            default: imem_gnt = !mem_busy && ($urandom_range(0, 1) == 1);
        endcase
        @(negedge clk);
    endtask

    task automatic advance();
        bit hs;
        bit req;
        hs = imem_req && imem_gnt;
        if (rst) begin
            q_pc.delete(); q_in.delete();
            m_pc  = 32'h0;
            m_out = 0;
        end else begin
            req = !m_out && !redirect_valid && (q_pc.size() < 2);
            if (redirect_valid) begin
                q_pc.delete(); q_in.delete();
                m_pc = {redirect_pc[31:2], 2'b00};
                if (m_out && imem_rvalid) m_out = 0;
                else if (m_out)           m_drop = 1;
            end else begin
                if (q_pc.size() != 0 && if_ready) begin
                    void'(q_pc.pop_front()); void'(q_in.pop_front());
                end
                if (m_out && imem_rvalid) begin
                    if (!m_drop) begin q_pc.push_back(m_addr); q_in.push_back(imem_rdata); end
                    m_out = 0;
                end
                if (req && imem_gnt) begin
                    m_out = 1; m_drop = 0; m_addr = m_pc; m_pc = m_pc + 32'd4;
                end
            end
        end
        if (mem_busy) begin
            if (mem_delay == 0) mem_busy = 0;
            else mem_delay--;
        end
        if (hs) begin
            mem_busy  = 1;
            mem_addr  = imem_addr;
            mem_delay = $urandom_range(lat_min, lat_max);
        end
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        mem_busy = 0;
        gnt_mode = 1; lat_min = 0; lat_max = 0; spurious_en = 0;
        redirect_valid = 1'b0; if_ready = 1'b1;
        rst = 1'b1;
        prep(); advance();
        prep(); advance();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; if_ready = 1'b1; gnt_mode = 1;
        for (int i = 0; i < 3; i++) begin
            redirect_valid = $urandom_range(0, 1);
            redirect_pc = $urandom;
            prep();
            if (i > 0) begin
                checks++;
                if (imem_req !== 1'b0 || if_valid !== 1'b0 || if_pc !== 32'h0 || if_instr !== 32'h0) begin
                    errors++;
                    $display("FAIL reset_outputs: got req=%b valid=%b pc=%h instr=%h, want 0,0,0,0",
                             imem_req, if_valid, if_pc, if_instr);
                end
            end
            advance();
        end
        rst = 1'b0; redirect_valid = 1'b0;
        prep();
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0 || if_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_first_req: got req=%b addr=%h valid=%b, want 1,00000000,0",
                     imem_req, imem_addr, if_valid);
        end
        advance();
        $display("test_reset done");
    endtask

    task automatic test_stream();
        int cyc[$];
        logic [31:0] pcs[$];
        do_reset();
        for (int c = 0; c < 10; c++) begin
            prep();
            if (if_valid && if_ready) begin
                cyc.push_back(c); pcs.push_back(if_pc);
                checks++;
                if (if_instr !== (if_pc ^ 32'hA5A5_0000)) begin
                    errors++;
                    $display("FAIL stream_instr: pc=%h got instr=%h want %h", if_pc, if_instr, if_pc ^ 32'hA5A5_0000);
                end
            end
            advance();
        end
        checks++;
        if (pcs.size() < 4) begin
            errors++;
            $display("FAIL stream_count: got %0d instructions, want at least 4", pcs.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (pcs[i] !== 32'(4 * i) || cyc[i] != 2 + 2 * i) begin
                    errors++;
                    $display("FAIL stream_seq[%0d]: got pc=%h at cycle %0d, want pc=%h at cycle %0d",
                             i, pcs[i], cyc[i], 32'(4 * i), 2 + 2 * i);
                end
            end
        end
        $display("test_stream done: %0d instructions", pcs.size());
    endtask

    task automatic test_backpressure();
        do_reset();
        if_ready = 1'b0;
        for (int c = 0; c < 10; c++) begin prep(); advance(); end
        if_ready = 1'b1;
        prep();
        checks++;
        if (if_valid !== 1'b1 || imem_req !== 1'b0 || if_pc !== 32'h0) begin
            errors++;
            $display("FAIL bp_full: got valid=%b req=%b pc=%h, want 1,0,00000000", if_valid, imem_req, if_pc);
        end
        advance();
        prep();
        checks++;
        if (if_valid !== 1'b1 || if_pc !== 32'h4 || imem_req !== 1'b1 || imem_addr !== 32'h8) begin
            errors++;
            $display("FAIL bp_resume: got valid=%b pc=%h req=%b addr=%h, want 1,00000004,1,00000008",
                     if_valid, if_pc, imem_req, imem_addr);
        end
        advance();
        $display("test_backpressure done");
    endtask

    task automatic test_redirect();
        bit seen = 0;
        do_reset();
        lat_min = 1; lat_max = 1;
        prep(); advance();                       // grant for address 0
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0102;
        prep();
        checks++;
        if (imem_req !== 1'b0) begin
            errors++;
            $display("FAIL redir_req_low: got req=%b want 0", imem_req);
        end
        advance();
        redirect_valid = 1'b0;
        prep();                                  // stale response arrives here
        checks++;
        if (if_valid !== 1'b0 || imem_req !== 1'b0) begin
            errors++;
            $display("FAIL redir_drop: got valid=%b req=%b want 0,0", if_valid, imem_req);
        end
        advance();
        prep();
        checks++;
        if (if_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h0000_0100) begin
            errors++;
            $display("FAIL redir_target: got valid=%b req=%b addr=%h want 0,1,00000100", if_valid, imem_req, imem_addr);
        end
        advance();
        for (int c = 0; c < 10 && !seen; c++) begin
            prep();
            if (if_valid) begin
                seen = 1;
                checks++;
                if (if_pc !== 32'h100 || if_instr !== (32'h100 ^ 32'hA5A5_0000)) begin
                    errors++;
                    $display("FAIL redir_first_pc: got pc=%h instr=%h want 00000100,%h",
                             if_pc, if_instr, 32'h100 ^ 32'hA5A5_0000);
                end
            end
            advance();
        end
        if (!seen) begin
            errors++; checks++;
            $display("FAIL redir_timeout: got no instruction, want pc 00000100");
        end
        $display("test_redirect done");
    endtask

    task automatic test_gnt_stall();
        do_reset();
        gnt_mode = 0;
        for (int c = 0; c < 5; c++) begin
            prep();
            checks++;
            if (imem_req !== 1'b1 || imem_addr !== 32'h0 || if_valid !== 1'b0) begin
                errors++;
                $display("FAIL gnt_stall[%0d]: got req=%b addr=%h valid=%b want 1,00000000,0",
                         c, imem_req, imem_addr, if_valid);
            end
            advance();
        end
        $display("test_gnt_stall done");
    endtask

    task automatic test_wrap();
        logic [31:0] pcs[$];
        logic [31:0] ins[$];
        do_reset();
        for (int c = 0; c < 12; c++) begin
            prep();
            if (w_valid) begin pcs.push_back(w_pc); ins.push_back(w_instr); end
            advance();
        end
        checks++;
        if (pcs.size() < 2) begin
            errors++;
            $display("FAIL wrap_count: got %0d instructions want at least 2", pcs.size());
        end else if (pcs[0] !== 32'hFFFF_FFFC || pcs[1] !== 32'h0 ||
                     ins[0] !== (32'hFFFF_FFFC ^ 32'hA5A5_0000) || ins[1] !== 32'hA5A5_0000) begin
            errors++;
            $display("FAIL wrap_seq: got %h/%h then %h/%h want FFFFFFFC/5A5AFFFC then 00000000/A5A50000",
                     pcs[0], ins[0], pcs[1], ins[1]);
        end
        $display("test_wrap done");
    endtask

    task automatic test_reset_wait();
        bit seen = 0;
        do_reset();
        lat_min = 1; lat_max = 1;
        prep(); advance();                       // grant, response due two cycles later
        rst = 1'b1;
        prep(); advance();
        rst = 1'b0;
        prep();                                  // pre-reset response lands in IDLE
        advance();
        prep();
        checks++;
        if (if_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            errors++;
            $display("FAIL rst_wait_ignore: got valid=%b req=%b addr=%h want 0,1,00000000",
                     if_valid, imem_req, imem_addr);
        end
        advance();
        for (int c = 0; c < 10 && !seen; c++) begin
            prep();
            if (if_valid) begin
                seen = 1;
                checks++;
                if (if_pc !== 32'h0) begin
                    errors++;
                    $display("FAIL rst_wait_first_pc: got %h want 00000000", if_pc);
                end
            end
            advance();
        end
        if (!seen) begin
            errors++; checks++;
            $display("FAIL rst_wait_timeout: got no instruction want pc 00000000");
        end
        $display("test_reset_wait done");
    endtask

    task automatic test_random();
        bit exp_req;
        int pops = 0;
        do_reset();
        gnt_mode = 2; lat_min = 0; lat_max = 3; spurious_en = 1;
        for (int c = 0; c < 2000; c++) begin
            rst            = ($urandom_range(0, 99) == 0);
            redirect_valid = ($urandom_range(0, 9) == 0);
            redirect_pc    = $urandom;
            if_ready       = ($urandom_range(0, 2) != 0);
            prep();
            exp_req = !rst && !m_out && !redirect_valid && (q_pc.size() < 2);
            checks++;
            if (imem_req !== exp_req) begin
                errors++;
                $display("FAIL rnd_req cyc=%0d: got %b want %b", c, imem_req, exp_req);
            end
            if (exp_req) begin
                checks++;
                if (imem_addr !== m_pc) begin
                    errors++;
                    $display("FAIL rnd_addr cyc=%0d: got %h want %h", c, imem_addr, m_pc);
                end
            end
            checks++;
            if (if_valid !== (q_pc.size() != 0)) begin
                errors++;
                $display("FAIL rnd_valid cyc=%0d: got %b want %b", c, if_valid, q_pc.size() != 0);
            end
            if (q_pc.size() != 0) begin
                checks++;
                if (if_pc !== q_pc[0] || if_instr !== q_in[0]) begin
                    errors++;
                    $display("FAIL rnd_head cyc=%0d: got %h/%h want %h/%h", c, if_pc, if_instr, q_pc[0], q_in[0]);
                end
                if (if_ready && !redirect_valid && !rst) pops++;
            end
            advance();
        end
        rst = 1'b0; redirect_valid = 1'b0;
        $display("test_random done: %0d instructions consumed", pops);
    endtask

    initial begin
        @(posedge clk); #1;
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_gnt_stall();
        test_wrap();
        test_reset_wait();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/miriscv_fetch.md
MIRISCV_FETCH -- requirements
Module: miriscv_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port imem_req  output  1  fetch request to instruction memory.
REQ-005 SHALL have port imem_addr  output  32  byte address of the request, word-aligned.
REQ-006 SHALL have port imem_gnt  input  1  memory accepts the request this cycle.
REQ-007 SHALL have port imem_rvalid  input  1  read data valid.
REQ-008 SHALL have port imem_rdata  input  32  instruction word.
REQ-009 SHALL have port redirect_valid  input  1  branch/jump/trap redirect.
REQ-010 SHALL have port redirect_pc  input  32  redirect target.
REQ-011 SHALL have port if_valid  output  1  instruction available to decode.
REQ-012 SHALL have port if_ready  input  1  decode accepts the instruction.
REQ-013 SHALL have port if_instr  output  32  instruction at FIFO head.
REQ-014 SHALL have port if_pc  output  32  address of if_instr.

Function
REQ-015 SHALL hold fetch PC pc_q, a 2-entry FIFO of {pc, instr}, a count (0..2), and an FSM with states IDLE (no outstanding request), WAIT (one outstanding, response kept), DROP (one outstanding, response discarded).
REQ-016 SHALL allow at most one outstanding request; a request is accepted when imem_req & imem_gnt.
REQ-017 SHALL assert imem_req only in IDLE, with no redirect_valid this cycle, and count + 0 < 2 (a free slot exists for the response); imem_addr = pc_q.
REQ-018 SHALL hold imem_req and imem_addr stable while imem_gnt is low, unless redirect_valid arrives.
REQ-019 SHALL on grant move IDLE->WAIT, latch the request address, and set pc_q <= pc_q + 4 modulo 2^32 (32'hFFFF_FFFC wraps to 0).
REQ-020 SHALL in WAIT on imem_rvalid push {latched addr, imem_rdata} into the FIFO and move to IDLE; grant of a new request SHALL NOT occur in the same cycle (minimum one request per two cycles).
REQ-021 SHALL in DROP on imem_rvalid discard the data and move to IDLE.
REQ-022 SHALL ignore imem_rvalid in IDLE.
REQ-023 SHALL pop the FIFO head when if_valid & if_ready; if_valid = (count != 0); simultaneous push and pop leaves count unchanged and preserves order.
REQ-024 SHALL on redirect_valid: flush FIFO (count <= 0, if_valid low next cycle), set pc_q <= {redirect_pc[31:2], 2'b00}, deassert imem_req this cycle; WAIT without imem_rvalid -> DROP; WAIT with imem_rvalid -> IDLE, data discarded; DROP stays DROP unless imem_rvalid.
REQ-025 SHALL give redirect priority over push, pop and grant in the same cycle.
REQ-026 SHALL keep if_instr/if_pc stable while if_valid & !if_ready.

Reset
REQ-027 SHALL on rst: pc_q <= RESET_PC, count <= 0, FSM <= IDLE; imem_req, if_valid = 0 and if_instr, if_pc = 0 in the cycle after rst.
REQ-028 SHALL take priority of rst over all other inputs; a response to a pre-reset request arrives in IDLE and is ignored (REQ-022).

Verification
REQ-029 Reset, RESET_PC=0, gnt=1, memory rvalid one cycle after grant with rdata=addr^32'hA5A5_0000, if_ready=1 -> if_pc sequence 0,4,8,C with matching if_instr, one instruction per two cycles.
REQ-030 if_ready=0 for 10 cycles -> count saturates at 2, imem_req low, if_pc stays 0; if_ready=1 -> 0 then 4 pop in order, fetching resumes at 8.
REQ-031 redirect_valid with redirect_pc=32'h0000_0102 while WAIT, rvalid next cycle -> data dropped, FIFO empty, next imem_addr=32'h0000_0100, next if_pc=32'h100.
REQ-032 gnt held 0 for 5 cycles -> imem_req=1, imem_addr constant; no FIFO push.
REQ-033 RESET_PC=32'hFFFF_FFFC -> if_pc sequence FFFF_FFFC, 0000_0000.
REQ-034 rst asserted while WAIT, rvalid the following cycle -> ignored; first if_pc after reset = RESET_PC.
